// File: rtl/sen_sched.sv
// Sensor-command scheduler: queues bus write commands, raises periodic round-robin read
// polls and serialises both onto one req/ack/done port, guarded by a transaction watchdog.
//
// state     | meaning
// IDLE      | no transaction; picks the FIFO head, else a pending poll
// REQ       | tx_req high, waiting for tx_ack
// WAIT_DONE | accepted by the transmitter, waiting for tx_done
module sen_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] POLL_DIV   = 16'd50000,
    parameter int unsigned N_SENSOR   = 4,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [39:0]                 sen_cmd,
    input  logic                        sen_cmd_flag,
    input  logic                        poll_en,
    output logic [39:0]                 tx_cmd,
    output logic                        tx_rd,
    output logic                        tx_req,
    input  logic                        tx_ack,
    input  logic                        tx_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        drop_flag,
    output logic                        timeout_flag
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  LAST_ID  = 8'(N_SENSOR);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [39:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full, push, pop;
    logic [15:0]   poll_cnt, wd_cnt;
    logic          poll_pend, poll_wrap;
    logic [7:0]    poll_id;
    logic          issue_wr, issue_poll, wd_expired, timeout_evt;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign issue_wr   = (state == IDLE) && !fifo_empty;
    assign issue_poll = (state == IDLE) && fifo_empty && poll_pend;
    assign pop        = issue_wr;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push       = sen_cmd_flag && (!fifo_full || pop);
    assign poll_wrap  = poll_en && (poll_cnt == POLL_DIV - 16'd1);
    // Compare with >= so an ack landing on the expiry cycle still bounds WAIT_DONE.
    assign wd_expired = (wd_cnt >= TIMEOUT - 16'd1);

    assign tx_req = (state == REQ);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (issue_wr || issue_poll) state_nxt = REQ;
            end
            REQ: begin
                if (tx_ack) begin
                    state_nxt = tx_done ? IDLE : WAIT_DONE;
                end else if (wd_expired) begin
                    state_nxt   = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end else if (wd_expired) begin
                    state_nxt   = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state        <= IDLE;
            wd_cnt       <= '0;
            tx_cmd       <= '0;
            tx_rd        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            wd_cnt       <= (state == IDLE) ? '0 : wd_cnt + 16'd1;
            timeout_flag <= timeout_evt;
            if (issue_wr) begin
                tx_cmd <= fifo_mem[rd_ptr];
                tx_rd  <= 1'b0;
            end else if (issue_poll) begin
                tx_cmd <= {poll_id, 32'h0};
                tx_rd  <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
            poll_id   <= 8'h01;
        end else begin
            if (!poll_en) begin
                poll_cnt  <= '0;
                poll_pend <= 1'b0;
            end else begin
                poll_cnt <= poll_wrap ? '0 : poll_cnt + 16'd1;
                if (issue_poll)     poll_pend <= 1'b0;
                else if (poll_wrap) poll_pend <= 1'b1;
            end
            if (issue_poll) poll_id <= (poll_id == LAST_ID) ? 8'h01 : poll_id + 8'h01;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr] <= sen_cmd;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            drop_flag <= 1'b0;
        end else begin
            drop_flag <= sen_cmd_flag && !push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sen_sched.sv
// Bench for sen_sched: directed scenarios plus randomized traffic, every cycle compared
// against a queue-based transaction model of the scheduler.
module tb_sen_sched;

    localparam int          DEPTH = 4;
    localparam logic [15:0] DIV   = 16'd8;
    localparam int          NS    = 3;
    localparam logic [15:0] TMO   = 16'd16;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [39:0] sen_cmd = '0;
    logic        sen_cmd_flag = 1'b0, poll_en = 1'b0, tx_ack = 1'b0, tx_done = 1'b0;
    logic [39:0] tx_cmd;
    logic        tx_rd, tx_req, busy, drop_flag, timeout_flag;
    logic [2:0]  fifo_cnt;

    sen_sched #(.FIFO_DEPTH(DEPTH), .POLL_DIV(DIV), .N_SENSOR(NS), .TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sen_cmd(sen_cmd), .sen_cmd_flag(sen_cmd_flag),
        .poll_en(poll_en), .tx_cmd(tx_cmd), .tx_rd(tx_rd), .tx_req(tx_req), .tx_ack(tx_ack),
        .tx_done(tx_done), .busy(busy), .fifo_cnt(fifo_cnt), .drop_flag(drop_flag),
        .timeout_flag(timeout_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // reference model: pending writes as a queue, transaction phase, elapsed cycles
    logic [39:0] m_q[$];
    int          m_phase, m_wd, m_pcnt;
    logic [39:0] m_cmd;
    logic        m_rd, m_pend, m_drop, m_tmo;
    logic [7:0]  m_pid;

    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [39:0] ev_cmd[$];
    logic        ev_rd[$];
    int          ev_cyc[$];
    logic        prev_req = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_phase = P_IDLE; m_wd = 0; m_pcnt = 0;
        m_cmd = '0; m_rd = 1'b0; m_pend = 1'b0; m_drop = 1'b0; m_tmo = 1'b0;
        m_pid = 8'h01;
    endfunction

    function automatic void model_step();
        logic [39:0] head;
        logic        take_wr, take_poll, wrap;
        head = '0;
        m_drop = 1'b0;
        m_tmo  = 1'b0;
        take_wr   = (m_phase == P_IDLE) && (m_q.size() != 0);
        take_poll = (m_phase == P_IDLE) && !take_wr && m_pend;
        if (take_wr) head = m_q.pop_front();
        if (sen_cmd_flag) begin
            if (m_q.size() < DEPTH) m_q.push_back(sen_cmd);
            else m_drop = 1'b1;
        end
        wrap = poll_en && (m_pcnt == int'(DIV) - 1);
        case (m_phase)
            P_IDLE: begin
                if (take_wr) begin
                    m_cmd = head; m_rd = 1'b0; m_phase = P_REQ; m_wd = 0;
                end else if (take_poll) begin
                    m_cmd = {m_pid, 32'h0}; m_rd = 1'b1; m_phase = P_REQ; m_wd = 0;
                    m_pid = (m_pid == 8'(NS)) ? 8'h01 : m_pid + 8'h01;
                end
            end
            P_REQ: begin
                if (tx_ack) m_phase = tx_done ? P_IDLE : P_WAIT;
                else if (m_wd >= int'(TMO) - 1) begin m_phase = P_IDLE; m_tmo = 1'b1; end
                m_wd++;
            end
            default: begin
                if (tx_done) m_phase = P_IDLE;
                else if (m_wd >= int'(TMO) - 1) begin m_phase = P_IDLE; m_tmo = 1'b1; end
                m_wd++;
            end
        endcase
        if (!poll_en) begin
            m_pcnt = 0; m_pend = 1'b0;
        end else begin
            m_pcnt = wrap ? 0 : m_pcnt + 1;
            if (take_poll) m_pend = 1'b0;
            else if (wrap) m_pend = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        check_eq("tx_req",       64'(tx_req),       64'(m_phase == P_REQ));
        check_eq("busy",         64'(busy),         64'(m_phase != P_IDLE));
        check_eq("tx_cmd",       64'(tx_cmd),       64'(m_cmd));
        check_eq("tx_rd",        64'(tx_rd),        64'(m_rd));
        check_eq("fifo_cnt",     64'(fifo_cnt),     64'(m_q.size()));
        check_eq("drop_flag",    64'(drop_flag),    64'(m_drop));
        check_eq("timeout_flag", 64'(timeout_flag), 64'(m_tmo));
    endtask

    task automatic step_rec(input logic f, input logic [39:0] c, input logic en,
                            input logic a, input logic d);
        @(negedge sys_clk);
        check_outputs();
        sen_cmd_flag = f; sen_cmd = c; poll_en = en; tx_ack = a; tx_done = d;
        @(posedge sys_clk);
        model_step();
        cyc++;
        #1;
        if (tx_req && !prev_req) begin
            ev_cmd.push_back(tx_cmd); ev_rd.push_back(tx_rd); ev_cyc.push_back(cyc);
        end
        prev_req = tx_req;
    endtask

    task automatic ev_clear();
        ev_cmd.delete(); ev_rd.delete(); ev_cyc.delete();
        prev_req = tx_req;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (!(m_phase == P_IDLE && m_q.size() == 0 && !m_pend) && i < 200) begin
            step_rec(1'b0, '0, 1'b0, m_phase == P_REQ, m_phase != P_IDLE);
            i++;
        end
        check_eq("drain_bound", 64'(i < 200), 64'd1);
        repeat (2) step_rec(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_checks(input string pfx);
        check_eq({pfx, "_tx_req"},   64'(tx_req),       64'd0);
        check_eq({pfx, "_busy"},     64'(busy),         64'd0);
        check_eq({pfx, "_tx_cmd"},   64'(tx_cmd),       64'd0);
        check_eq({pfx, "_tx_rd"},    64'(tx_rd),        64'd0);
        check_eq({pfx, "_fifo_cnt"}, 64'(fifo_cnt),     64'd0);
        check_eq({pfx, "_drop"},     64'(drop_flag),    64'd0);
        check_eq({pfx, "_timeout"},  64'(timeout_flag), 64'd0);
    endtask

    initial begin
        int n_drop, n_tmo, tmo_cyc, ap, dp, wp, chunk_en;
        logic [39:0] rnd;
        logic a, d, en;

        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        reset_checks("rst");
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;

        // poll round-robin, prompt ack+done
        ev_clear();
        for (int i = 0; i < 60; i++)
            step_rec(1'b0, '0, 1'b1, m_phase == P_REQ, m_phase == P_REQ);
        check_eq("poll_n", 64'(ev_cmd.size()), 64'd7);
        if (ev_cmd.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                check_eq("poll_id", 64'(ev_cmd[k][39:32]), 64'(k % 3 + 1));
                check_eq("poll_rd", 64'(ev_rd[k]), 64'd1);
                if (k > 0) check_eq("poll_gap", 64'(ev_cyc[k] - ev_cyc[k-1]), 64'd8);
            end
        end
        drain();

        // single write
        step_rec(1'b1, 40'h02_DEADBEEF, 1'b0, 1'b0, 1'b0);
        check_eq("wr_cnt_t1", 64'(fifo_cnt), 64'd1);
        check_eq("wr_req_t1", 64'(tx_req), 64'd0);
        step_rec(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("wr_req_t2", 64'(tx_req), 64'd1);
        check_eq("wr_cmd", 64'(tx_cmd), 64'h02_DEADBEEF);
        check_eq("wr_rd", 64'(tx_rd), 64'd0);
        check_eq("wr_cnt_t2", 64'(fifo_cnt), 64'd0);
        repeat (3) step_rec(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step_rec(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_eq("wr_req_fall", 64'(tx_req), 64'd0);
        repeat (4) step_rec(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("wr_busy_wait", 64'(busy), 64'd1);
        step_rec(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("wr_busy_fall", 64'(busy), 64'd0);
        drain();

        // FIFO full: six writes with no ack
        ev_clear();
        n_drop = 0;
        for (int i = 1; i <= 6; i++) begin
            step_rec(1'b1, {8'(i), $urandom}, 1'b0, 1'b0, 1'b0);
            if (drop_flag) n_drop++;
            if (i == 5) begin
                check_eq("full_cnt", 64'(fifo_cnt), 64'd4);
                check_eq("full_head_id", 64'(tx_cmd[39:32]), 64'd1);
                check_eq("full_head_req", 64'(tx_req), 64'd1);
            end
        end
        for (int i = 0; i < 60 && !(m_phase == P_IDLE && m_q.size() == 0); i++) begin
            step_rec(1'b0, '0, 1'b0, m_phase == P_REQ, m_phase == P_REQ);
            if (drop_flag) n_drop++;
        end
        check_eq("full_drops", 64'(n_drop), 64'd1);
        check_eq("full_n_out", 64'(ev_cmd.size()), 64'd5);
        if (ev_cmd.size() == 5)
            for (int k = 0; k < 5; k++) check_eq("full_order", 64'(ev_cmd[k][39:32]), 64'(k + 1));
        drain();

        // write and poll wrap land together; a second wrap during the write is absorbed
        ev_clear();
        for (int k = 0; k < 24; k++) begin
            a = (m_phase == P_REQ) && (m_rd || k >= 10);
            d = ((m_phase == P_WAIT) && k >= 20) || ((m_phase == P_REQ) && m_rd);
            step_rec(k == 7, {8'h0A, $urandom}, 1'b1, a, d);
        end
        check_eq("prio_n", 64'(ev_cmd.size()), 64'd2);
        if (ev_cmd.size() >= 2) begin
            check_eq("prio_first_rd", 64'(ev_rd[0]), 64'd0);
            check_eq("prio_first_id", 64'(ev_cmd[0][39:32]), 64'h0A);
            check_eq("prio_second_rd", 64'(ev_rd[1]), 64'd1);
        end
        drain();

        // watchdog: first write hangs, second is acked in its expiry cycle
        ev_clear();
        n_tmo = 0; tmo_cyc = -1;
        step_rec(1'b1, {8'h0B, $urandom}, 1'b0, 1'b0, 1'b0);
        step_rec(1'b1, {8'h0C, $urandom}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 80 && !(ev_cmd.size() == 2 && m_phase == P_IDLE && m_q.size() == 0); i++) begin
            a = (m_phase == P_REQ) && (m_cmd[39:32] == 8'h0C) && (m_wd == int'(TMO) - 1);
            step_rec(1'b0, '0, 1'b0, a, m_phase == P_WAIT);
            if (timeout_flag) begin n_tmo++; tmo_cyc = cyc; end
        end
        check_eq("tmo_pulses", 64'(n_tmo), 64'd1);
        check_eq("tmo_n_issued", 64'(ev_cmd.size()), 64'd2);
        if (ev_cmd.size() == 2) begin
            check_eq("tmo_latency", 64'(tmo_cyc - ev_cyc[0]), 64'd16);
            check_eq("tmo_next_gap", 64'(ev_cyc[1] - ev_cyc[0]), 64'd17);
            check_eq("tmo_next_id", 64'(ev_cmd[1][39:32]), 64'h0C);
        end
        drain();

        // asynchronous reset during WAIT_DONE with two writes queued
        step_rec(1'b1, {8'h21, $urandom}, 1'b0, 1'b0, 1'b0);
        step_rec(1'b1, {8'h22, $urandom}, 1'b0, 1'b0, 1'b0);
        step_rec(1'b1, {8'h23, $urandom}, 1'b0, 1'b0, 1'b0);
        step_rec(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_eq("mid_busy", 64'(busy), 64'd1);
        check_eq("mid_cnt", 64'(fifo_cnt), 64'd2);
        #2;
        sys_rst = 1'b0;
        sen_cmd_flag = 1'b0; sen_cmd = '0; poll_en = 1'b0; tx_ack = 1'b0; tx_done = 1'b0;
        #1;
        reset_checks("arst");
        model_reset();
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        prev_req = 1'b0;

        // randomized traffic, including hung and spurious handshakes
        for (int ch = 0; ch < 16; ch++) begin
            wp = $urandom_range(0, 60);
            ap = (ch % 4 == 3) ? 0 : $urandom_range(10, 100);
            dp = (ch % 5 == 4) ? 0 : $urandom_range(10, 100);
            chunk_en = $urandom_range(0, 1);
            for (int i = 0; i < 250; i++) begin
                rnd = {8'($urandom), $urandom};
                en = 1'(chunk_en) ^ ($urandom_range(0, 99) < 2);
                a = (m_phase == P_REQ) ? ($urandom_range(0, 99) < ap) : ($urandom_range(0, 99) < 5);
                if (m_phase == P_WAIT)     d = $urandom_range(0, 99) < dp;
                else if (m_phase == P_REQ) d = a && ($urandom_range(0, 99) < 50);
                else                       d = $urandom_range(0, 99) < 5;
                step_rec($urandom_range(0, 99) < wp, rnd, en, a, d);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sen_sched.md
# sen_sched

Sensor-command scheduler between the bus receive parser and the sensor transmitter. It buffers bus-issued sensor write commands (40-bit `{id, data}` with a one-cycle strobe) in a small FIFO. It also generates periodic round-robin read polls of the attached sensors. It serialises both sources onto a single req/ack/done transaction port, with writes taking priority, and applies a watchdog timeout so a hung transaction cannot stall the port.

## Interface
- `FIFO_DEPTH`, 4: write-command FIFO depth; power of two, ≥2.
- `POLL_DIV`, 16'd50000: `sys_clk` cycles between poll requests.
- `N_SENSOR`, 4: polled sensor IDs run 8'h01..N_SENSOR; range 1..255.
- `TIMEOUT`, 16'd1000: maximum cycles spent in REQ+WAIT_DONE per transaction.
- `sys_clk` in 1: the single clock; all logic on its rising edge.
- `sys_rst` in 1: asynchronous, active-low reset.
- `sen_cmd` in 40: `[39:32]` sensor ID, `[31:0]` write data; sampled when `sen_cmd_flag`=1.
- `sen_cmd_flag` in 1: one-cycle write-command strobe.
- `poll_en` in 1: level; enables periodic polling.
- `tx_cmd` out 40: command to the transmitter; stable while `busy`=1.
- `tx_rd` out 1: 1 = read poll (`tx_cmd[31:0]`=0), 0 = write.
- `tx_req` out 1: request; held high until `tx_ack`.
- `tx_ack` in 1: one-cycle acceptance pulse from the transmitter.
- `tx_done` in 1: one-cycle transaction-complete pulse.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `fifo_cnt` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `drop_flag` out 1: one-cycle pulse when a write is lost because the FIFO is full.
- `timeout_flag` out 1: one-cycle pulse on watchdog expiry.

## Operation
- **Reset values:**
  - `tx_cmd`=0, `tx_rd`=0, `tx_req`=0, `busy`=0, `fifo_cnt`=0.
  - `drop_flag`=0, `timeout_flag`=0.
  - Internal: FSM=IDLE, poll counter=0, `poll_pend`=0, `poll_id`=8'h01, watchdog=0.
  - Reset mid-transaction aborts it immediately and empties the FIFO.
- **FIFO:** circular buffer with wrapping read/write pointers.
  - A push on `sen_cmd_flag` is accepted if `fifo_cnt`<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the command is discarded and `drop_flag` pulses the next cycle.
  - A simultaneous push and pop leaves `fifo_cnt` unchanged.
- **Poll timer:**
  - With `poll_en`=1, the counter counts 0..POLL_DIV-1 and wraps; the wrap sets `poll_pend`.
  - A wrap while `poll_pend` is already 1 is absorbed; pending polls do not accumulate.
  - With `poll_en`=0, the counter is held at 0 and `poll_pend` is cleared.
- **FSM states:**
  - IDLE:
    - If the FIFO is non-empty: load the FIFO head into `tx_cmd`, set `tx_rd`=0, pop, go to REQ.
    - Else if `poll_pend`: set `tx_cmd`={`poll_id`, 32'h0} and `tx_rd`=1, clear `poll_pend`, go to REQ. Then advance `poll_id`; it wraps from N_SENSOR to 8'h01.
    - Otherwise stay in IDLE.
  - REQ: `tx_req`=1.
    - `tx_ack` with `tx_done` in the same cycle: go to IDLE.
    - `tx_ack` alone: go to WAIT_DONE.
  - WAIT_DONE: `tx_done` returns to IDLE.
  - `tx_ack` or `tx_done` arriving while in IDLE is ignored.
- **Watchdog:**
  - Cleared in IDLE; increments every cycle in REQ and WAIT_DONE.
  - On reaching TIMEOUT-1 without the exit event: go to IDLE, pulse `timeout_flag`, drop the command (no retry).
  - If the exit event (`tx_ack` in REQ, `tx_done` in WAIT_DONE) arrives in the expiry cycle, the exit event wins and no timeout is signalled.
- `tx_req` and `busy` are decoded from the registered state (glitch-free).

## Timing
- Write latency: `sen_cmd_flag` in cycle t with the FIFO empty and the FSM in IDLE.
  - `fifo_cnt`=1 in t+1.
  - `tx_req`=1 and `tx_cmd` valid in t+2; `fifo_cnt`=0 in t+2.
- Poll latency: wrap at the edge ending cycle t with the FIFO empty and the FSM in IDLE gives `tx_req`=1 in t+2.
- `tx_req` falls in the cycle after `tx_ack`.
- Minimum spacing between back-to-back transactions: 1 IDLE cycle.
- `drop_flag` and `timeout_flag` are registered pulses, exactly 1 cycle wide.

## Test plan
- **Single write:**
  - Stimulus: pulse `sen_cmd`=40'h02_DEADBEEF; `tx_ack` 3 cycles after `tx_req`; `tx_done` 5 cycles later.
  - Required: `tx_req` high in t+2, `tx_cmd`=40'h02_DEADBEEF, `tx_rd`=0, `busy` falls the cycle after `tx_done`.
- **FIFO full:**
  - Stimulus: hold `tx_ack` low; pulse 6 writes with IDs 01..06.
  - Required: the first write is in REQ; IDs 02..05 fill the FIFO (`fifo_cnt`=4); ID 06 gives one `drop_flag` pulse.
  - Then ack/done each transaction: outputs in order 01..05.
- **Poll round-robin:**
  - Stimulus: POLL_DIV=8, N_SENSOR=3, `poll_en`=1; ack and done promptly.
  - Required: `tx_rd`=1 with IDs 01, 02, 03, 01 …, one request every 8 cycles.
- **Priority and absorb:**
  - Stimulus: a write is queued in the same cycle `poll_pend` sets.
  - Required: the write is issued first, then the poll. A second wrap during the write yields only one poll.
- **Timeout:**
  - Stimulus: TIMEOUT=16; `tx_ack` never arrives.
  - Required: `timeout_flag` pulses after 16 REQ cycles, FSM returns to IDLE, the next queued command is issued.
  - Repeat with `tx_ack` in the expiry cycle: no `timeout_flag`.
- **Reset mid-operation:**
  - Stimulus: assert `sys_rst`=0 during WAIT_DONE with `fifo_cnt`=2.
  - Required: all outputs at their reset values immediately (asynchronous), and `fifo_cnt`=0.
